mem_arbiter: RTL and testbench

//  Unified-memory successor to the split imem/dmem pair: one single-port word

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port word memory shared by instruction-fetch (IM) and data (DM) requesters,
// with programmable wait states and byte-enabled writes. Define ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 2048,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                im_req,
  input  logic [ADDR_W-1:0]   im_addr,
  output logic [DATA_W-1:0]   im_rdata,
  output logic                im_ack,
  input  logic                dm_cs,
  input  logic                dm_r,
  input  logic                dm_w,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                stall,
  output logic [1:0]          state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            st;
  logic [3:0]        cnt;
  logic              win_dm;
  logic              wr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [IDX_W-1:0]  idx_q;
  logic              grant_dm;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // dm_r carries no extra information: a request is a write whenever dm_w is set.
  logic unused_bits;
  assign unused_bits = ^{dm_r, im_addr[ADDR_W-1:IDX_W+2], im_addr[1:0],
                         dm_addr[ADDR_W-1:IDX_W+2], dm_addr[1:0]};

  assign state = st;
  assign stall = (im_req & ~im_ack) | (dm_cs & ~dm_ack);

`ifdef ARB_RR_EN
  logic rr_dm;
  assign grant_dm = dm_cs & (~im_req | rr_dm);
`else
  assign grant_dm = dm_cs;
`endif

  assign rd_word = mem[idx_q];
  assign mem_we  = (st == WAIT) && (cnt == 4'd0) && wr_q;

  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      cnt      <= 4'd0;
      win_dm   <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      im_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      im_rdata <= '0;
      dm_rdata <= '0;
`ifdef ARB_RR_EN
      rr_dm    <= 1'b1;
`endif
    end else begin
      im_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (st)
        IDLE: begin
          if (dm_cs | im_req) begin
            win_dm  <= grant_dm;
            wr_q    <= grant_dm & dm_w;
            be_q    <= dm_be;
            wdata_q <= dm_wdata;
            idx_q   <= grant_dm ? dm_addr[IDX_W+1:2] : im_addr[IDX_W+1:2];
            cnt     <= 4'(WAIT_CYCLES);
            st      <= WAIT;
`ifdef ARB_RR_EN
            // After a contested grant the loser gets priority next time.
            if (dm_cs & im_req) rr_dm <= ~grant_dm;
`endif
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // rd_word is the pre-write contents, so a write returns the old word.
            if (win_dm) begin
              dm_rdata <= rd_word;
              dm_ack   <= 1'b1;
            end else begin
              im_rdata <= rd_word;
              im_ack   <= 1'b1;
            end
            st <= RESP;
          end
        end
        RESP: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with 1, 0 and 3 wait states
// (index 0, 1, 2) share one clock; each has its own reset and request signals.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n    [3];
  logic        im_req   [3];
  logic [31:0] im_addr  [3];
  logic [31:0] im_rdata [3];
  logic        im_ack   [3];
  logic        dm_cs    [3];
  logic        dm_r     [3];
  logic        dm_w     [3];
  logic [3:0]  dm_be    [3];
  logic [31:0] dm_addr  [3];
  logic [31:0] dm_wdata [3];
  logic [31:0] dm_rdata [3];
  logic        dm_ack   [3];
  logic        stall    [3];
  logic [1:0]  state    [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(
      .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(2048),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) u_dut (
      .clk_in(clk), .reset(rst_n[g]),
      .im_req(im_req[g]), .im_addr(im_addr[g]), .im_rdata(im_rdata[g]), .im_ack(im_ack[g]),
      .dm_cs(dm_cs[g]), .dm_r(dm_r[g]), .dm_w(dm_w[g]), .dm_be(dm_be[g]),
      .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]), .dm_rdata(dm_rdata[g]), .dm_ack(dm_ack[g]),
      .stall(stall[g]), .state(state[g])
    );
  end

  // Drives one request from a negedge, waits for its ack, then returns one cycle later (IDLE).
  // lat is the number of negedges from request to ack (0 = never acked).
  task automatic access(input int k, input bit is_dm, input bit r, input bit w,
                        input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat, output int stall_bad);
    lat = 0;
    stall_bad = 0;
    rd = '0;
    if (is_dm) begin
      dm_cs[k] = 1'b1; dm_r[k] = r; dm_w[k] = w; dm_be[k] = be;
      dm_addr[k] = addr; dm_wdata[k] = wdata;
    end else begin
      im_req[k] = 1'b1; im_addr[k] = addr;
    end
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (is_dm ? dm_ack[k] : im_ack[k]) begin
        lat = i;
        rd = is_dm ? dm_rdata[k] : im_rdata[k];
      end else if (stall[k] !== 1'b1) begin
        stall_bad++;
      end
    end
    dm_cs[k] = 1'b0; dm_r[k] = 1'b0; dm_w[k] = 1'b0; im_req[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (state[0] !== 2'd0 || im_ack[0] !== 1'b0 || dm_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d im_ack=%b dm_ack=%b, want 0/0/0", state[0], im_ack[0], dm_ack[0]);
    end
    checks++;
    if (im_rdata[0] !== 32'h0 || dm_rdata[0] !== 32'h0 || stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: im_rdata=%h dm_rdata=%h stall=%b, want 0/0/0", im_rdata[0], dm_rdata[0], stall[0]);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] rd;
    int lat, sb;
    access(0, 1, 0, 1, 4'hF, 32'h0, 32'h2002_0001, rd, lat, sb);
    access(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, rd, lat, sb);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL fetch_latency: got %0d want 3", lat); end
    checks++;
    if (rd !== 32'h2002_0001) begin errors++; $display("FAIL fetch_data: got %h want 20020001", rd); end
    checks++;
    if (sb != 0) begin errors++; $display("FAIL fetch_stall: %0d low cycles, want 0", sb); end
    checks++;
    if (im_ack[0] !== 1'b0 || im_rdata[0] !== 32'h2002_0001) begin
      errors++;
      $display("FAIL fetch_hold: im_ack=%b im_rdata=%h, want 0/20020001", im_ack[0], im_rdata[0]);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd;
    int lat, sb;
    access(0, 1, 0, 1, 4'hF, 32'h40, 32'h1122_3344, rd, lat, sb);
    access(0, 1, 0, 1, 4'b0101, 32'h40, 32'hDEAD_BEEF, rd, lat, sb);
    checks++;
    if (rd !== 32'h1122_3344) begin errors++; $display("FAIL write_prevword: got %h want 11223344", rd); end
    access(0, 1, 1, 0, 4'h0, 32'h40, 32'h0, rd, lat, sb);
    checks++;
    if (rd !== 32'h11AD_33EF) begin errors++; $display("FAIL byte_enable: got %h want 11ad33ef", rd); end
    // neither read nor write: acked, memory untouched
    access(0, 1, 0, 0, 4'hF, 32'h40, 32'h0, rd, lat, sb);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL noop_ack: latency %0d want 3", lat); end
    access(0, 1, 1, 0, 4'h0, 32'h40, 32'h0, rd, lat, sb);
    checks++;
    if (rd !== 32'h11AD_33EF) begin errors++; $display("FAIL noop_untouched: got %h want 11ad33ef", rd); end
    // read and write together behaves as a write
    access(0, 1, 1, 1, 4'hF, 32'h44, 32'h0102_0304, rd, lat, sb);
    access(0, 0, 0, 0, 4'h0, 32'h44, 32'h0, rd, lat, sb);
    checks++;
    if (rd !== 32'h0102_0304) begin errors++; $display("FAIL rw_is_write: got %h want 01020304", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int lat, sb;
    access(0, 1, 0, 1, 4'hF, 32'h2000, 32'hCAFE_F00D, rd, lat, sb);
    access(0, 1, 1, 0, 4'h0, 32'h0, 32'h0, rd, lat, sb);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL addr_wrap: got %h want cafef00d", rd); end
  endtask

  task automatic test_arbitration();
    logic [1:0] seq[$];
    int nd = 0;
    im_req[0] = 1'b1; im_addr[0] = 32'h0;
    dm_cs[0] = 1'b1; dm_r[0] = 1'b1; dm_w[0] = 1'b0; dm_addr[0] = 32'h40;
    for (int i = 0; i < 80 && (im_req[0] || dm_cs[0]); i++) begin
      @(negedge clk);
      if (dm_ack[0]) begin
        seq.push_back(2'd1);
        nd++;
        if (nd == 3) dm_cs[0] = 1'b0;
      end
      if (im_ack[0]) begin
        seq.push_back(2'd2);
        im_req[0] = 1'b0;
      end
    end
    dm_cs[0] = 1'b0; dm_r[0] = 1'b0; im_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (seq.size() != 4) begin errors++; $display("FAIL arb_count: got %0d acks want 4", seq.size()); end
`ifdef ARB_RR_EN
    checks++;
    if (seq.size() < 3 || seq[0] !== 2'd1 || seq[1] !== 2'd2 || seq[2] !== 2'd1) begin
      errors++;
      $display("FAIL arb_rr_order: size %0d, want DM,IM,DM (1,2,1)", seq.size());
    end
`else
    checks++;
    if (seq.size() < 4 || seq[0] !== 2'd1 || seq[1] !== 2'd1 || seq[2] !== 2'd1 || seq[3] !== 2'd2) begin
      errors++;
      $display("FAIL arb_fixed_order: size %0d, want DM,DM,DM,IM (1,1,1,2)", seq.size());
    end
`endif
  endtask

  task automatic test_latency();
    logic [31:0] rd;
    int lat, sb;
    access(1, 0, 0, 0, 4'h0, 32'h8, 32'h0, rd, lat, sb);
    checks++;
    if (lat != 2 || sb != 0) begin errors++; $display("FAIL latency_w0: got %0d stall_low %0d, want 2/0", lat, sb); end
    access(2, 1, 1, 0, 4'h0, 32'h8, 32'h0, rd, lat, sb);
    checks++;
    if (lat != 5 || sb != 0) begin errors++; $display("FAIL latency_w3: got %0d stall_low %0d, want 5/0", lat, sb); end
  endtask

  task automatic test_drop_after_grant();
    bit seen = 0;
    logic [31:0] rd = '0;
    dm_cs[0] = 1'b1; dm_r[0] = 1'b1; dm_w[0] = 1'b0; dm_addr[0] = 32'h40;
    @(negedge clk);
    dm_cs[0] = 1'b0; dm_r[0] = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dm_ack[0]) begin seen = 1; rd = dm_rdata[0]; end
    end
    @(negedge clk);
    checks++;
    if (!seen || rd !== 32'h11AD_33EF) begin
      errors++;
      $display("FAIL drop_after_grant: ack=%0d data=%h, want 1/11ad33ef", seen, rd);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    int lat, sb;
    bit seen = 0;
    access(2, 1, 0, 1, 4'hF, 32'h80, 32'h5566_7788, rd, lat, sb);
    dm_cs[2] = 1'b1; dm_w[2] = 1'b1; dm_be[2] = 4'hF; dm_addr[2] = 32'h80; dm_wdata[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state[2] !== 2'd1) begin errors++; $display("FAIL mid_write_in_wait: state %0d want 1", state[2]); end
    rst_n[2] = 1'b0;
    #1;
    checks++;
    if (state[2] !== 2'd0 || dm_ack[2] !== 1'b0 || dm_rdata[2] !== 32'h0 || im_rdata[2] !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: state=%0d dm_ack=%b dm_rdata=%h im_rdata=%h, want 0", state[2], dm_ack[2], dm_rdata[2], im_rdata[2]);
    end
    dm_cs[2] = 1'b0; dm_w[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) rst_n[2] = 1'b1;
      if (dm_ack[2]) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_no_ack: ack seen, want none"); end
    access(2, 1, 1, 0, 4'h0, 32'h80, 32'h0, rd, lat, sb);
    checks++;
    if (rd !== 32'h5566_7788) begin errors++; $display("FAIL reset_word_kept: got %h want 55667788", rd); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; im_req[k] = 1'b0; im_addr[k] = '0;
      dm_cs[k] = 1'b0; dm_r[k] = 1'b0; dm_w[k] = 1'b0; dm_be[k] = '0;
      dm_addr[k] = '0; dm_wdata[k] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    test_reset();
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    test_fetch();
    test_byte_enable();
    test_wrap();
    test_arbitration();
    test_latency();
    test_drop_after_grant();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
